// File: rtl/sram_req_arbiter.sv
// Arbitrates the inst-fetch and data-access sram-like requesters onto one downstream port.
// An in-order owner FIFO routes each data_ok/rdata back to the requester that issued it.
module sram_req_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        aclk,
  input  logic        aresetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,

  output logic        out_sram_req,
  output logic        out_sram_wr,
  output logic [1:0]  out_sram_size,
  output logic [3:0]  out_sram_wstrb,
  output logic [31:0] out_sram_addr,
  output logic [31:0] out_sram_wdata,
  input  logic        out_sram_addr_ok,
  input  logic        out_sram_data_ok,
  input  logic [31:0] out_sram_rdata,

  output logic        err_unexpected_ok
);

  localparam int PTR_W    = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W    = PTR_W + 1;
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]    CNT_FULL   = CNT_W'(MAX_OUTSTANDING);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    OWNER_NONE,
    OWNER_INST,
    OWNER_DATA
  } owner_e;

  owner_e                     owner;
  logic                       lock_valid;
  logic                       lock_owner;
  logic [STARVE_W-1:0]        starve_cnt;
  logic [CNT_W-1:0]           count;
  logic [PTR_W-1:0]           wr_ptr;
  logic [PTR_W-1:0]           rd_ptr;
  logic [MAX_OUTSTANDING-1:0] fifo_mem;
  logic                       full;
  logic                       handshake;
  logic                       pop;
  logic                       head_owner;

  // A pending lock wins so the requester's fields stay on the bus until addr_ok.
  always_comb begin
    owner = OWNER_NONE;
    if (lock_valid) begin
      owner = lock_owner ? OWNER_DATA : OWNER_INST;
    end else if (starve_cnt == STARVE_MAX && inst_sram_req) begin
      owner = OWNER_INST;
    end else if (data_sram_req) begin
      owner = OWNER_DATA;
    end else if (inst_sram_req) begin
      owner = OWNER_INST;
    end
  end

  assign full         = (count == CNT_FULL);
  assign out_sram_req = (owner != OWNER_NONE) && !full;
  assign handshake    = out_sram_req && out_sram_addr_ok;
  assign pop          = out_sram_data_ok && (count != '0);
  assign head_owner   = fifo_mem[rd_ptr];

  always_comb begin
    out_sram_wr    = 1'b0;
    out_sram_size  = 2'b0;
    out_sram_wstrb = 4'b0;
    out_sram_addr  = 32'b0;
    out_sram_wdata = 32'b0;
    case (owner)
      OWNER_INST: begin
        out_sram_wr    = inst_sram_wr;
        out_sram_size  = inst_sram_size;
        out_sram_wstrb = inst_sram_wstrb;
        out_sram_addr  = inst_sram_addr;
        out_sram_wdata = inst_sram_wdata;
      end
      OWNER_DATA: begin
        out_sram_wr    = data_sram_wr;
        out_sram_size  = data_sram_size;
        out_sram_wstrb = data_sram_wstrb;
        out_sram_addr  = data_sram_addr;
        out_sram_wdata = data_sram_wdata;
      end
      default: ;
    endcase
  end

  assign inst_sram_addr_ok = handshake && (owner == OWNER_INST);
  assign data_sram_addr_ok = handshake && (owner == OWNER_DATA);
  assign inst_sram_data_ok = pop && !head_owner;
  assign data_sram_data_ok = pop && head_owner;
  assign inst_sram_rdata   = inst_sram_data_ok ? out_sram_rdata : 32'b0;
  assign data_sram_rdata   = data_sram_data_ok ? out_sram_rdata : 32'b0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      lock_valid        <= 1'b0;
      lock_owner        <= 1'b0;
      starve_cnt        <= '0;
      count             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_mem          <= '0;
      err_unexpected_ok <= 1'b0;
    end else begin
      if (handshake) begin
        lock_valid <= 1'b0;
      end else if (out_sram_req) begin
        lock_valid <= 1'b1;
        lock_owner <= (owner == OWNER_DATA);
      end

      if (handshake) begin
        fifo_mem[wr_ptr] <= (owner == OWNER_DATA);
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({handshake, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase

      if (out_sram_data_ok && count == '0) begin
        err_unexpected_ok <= 1'b1;
      end

      // Counts data wins only while inst is actually waiting; saturates at the limit.
      if (!inst_sram_req) begin
        starve_cnt <= '0;
      end else if (handshake && owner == OWNER_INST) begin
        starve_cnt <= '0;
      end else if (handshake && owner == OWNER_DATA && starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: inputs change on the falling edge and the
// combinational outputs are checked 1 ns later, well away from the rising edge.
module tb_sram_req_arbiter;

  logic        aclk;
  logic        aresetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        out_sram_req, out_sram_wr;
  logic [1:0]  out_sram_size;
  logic [3:0]  out_sram_wstrb;
  logic [31:0] out_sram_addr, out_sram_wdata;
  logic        out_sram_addr_ok, out_sram_data_ok;
  logic [31:0] out_sram_rdata;
  logic        err_unexpected_ok;

  int total = 0;
  int bad   = 0;

  sram_req_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
    .aclk              (aclk),
    .aresetn           (aresetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_wstrb   (data_sram_wstrb),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .out_sram_req      (out_sram_req),
    .out_sram_wr       (out_sram_wr),
    .out_sram_size     (out_sram_size),
    .out_sram_wstrb    (out_sram_wstrb),
    .out_sram_addr     (out_sram_addr),
    .out_sram_wdata    (out_sram_wdata),
    .out_sram_addr_ok  (out_sram_addr_ok),
    .out_sram_data_ok  (out_sram_data_ok),
    .out_sram_rdata    (out_sram_rdata),
    .err_unexpected_ok (err_unexpected_ok)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkBit(input string tag, input logic observed, input logic expected);
    checkOutput(tag, 32'(observed), 32'(expected));
  endtask

  // One cycle of stimulus: drive on the falling edge, settle, then the caller checks.
  task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                               input logic dreq, input logic [31:0] daddr,
                               input logic aok, input logic dok, input logic [31:0] rd);
    @(negedge aclk);
    inst_sram_req    = ireq;
    inst_sram_addr   = iaddr;
    data_sram_req    = dreq;
    data_sram_addr   = daddr;
    out_sram_addr_ok = aok;
    out_sram_data_ok = dok;
    out_sram_rdata   = rd;
    #1;
  endtask

  task automatic applyReset(input int cycles);
    @(negedge aclk);
    aresetn          = 1'b0;
    inst_sram_req    = 1'b0;
    data_sram_req    = 1'b0;
    out_sram_addr_ok = 1'b0;
    out_sram_data_ok = 1'b0;
    out_sram_rdata   = 32'h0;
    repeat (cycles) @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  initial begin
    aresetn          = 1'b0;
    inst_sram_req    = 1'b0;
    inst_sram_wr     = 1'b0;
    inst_sram_size   = 2'd2;
    inst_sram_wstrb  = 4'h0;
    inst_sram_addr   = 32'h0;
    inst_sram_wdata  = 32'h0;
    data_sram_req    = 1'b0;
    data_sram_wr     = 1'b1;
    data_sram_size   = 2'd2;
    data_sram_wstrb  = 4'hf;
    data_sram_addr   = 32'h0;
    data_sram_wdata  = 32'hCAFE0000;
    out_sram_addr_ok = 1'b0;
    out_sram_data_ok = 1'b0;
    out_sram_rdata   = 32'h0;

    // Reset state
    applyReset(2);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("rst_out_req", out_sram_req, 1'b0);
    checkBit("rst_inst_addr_ok", inst_sram_addr_ok, 1'b0);
    checkBit("rst_data_data_ok", data_sram_data_ok, 1'b0);
    checkBit("rst_err", err_unexpected_ok, 1'b0);
    checkOutput("rst_out_addr", out_sram_addr, 32'h0);

    // Single inst read
    applyStimulus(1, 32'h1C000000, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t1_out_req", out_sram_req, 1'b1);
    checkOutput("t1_out_addr", out_sram_addr, 32'h1C000000);
    checkBit("t1_out_wr", out_sram_wr, 1'b0);
    checkBit("t1_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    checkBit("t1_data_addr_ok", data_sram_addr_ok, 1'b0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("t1_idle_inst_data_ok", inst_sram_data_ok, 1'b0);
    checkBit("t1_idle_out_req", out_sram_req, 1'b0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h02800000);
    checkBit("t1_inst_data_ok", inst_sram_data_ok, 1'b1);
    checkOutput("t1_inst_rdata", inst_sram_rdata, 32'h02800000);
    checkBit("t1_data_data_ok", data_sram_data_ok, 1'b0);
    checkOutput("t1_data_rdata", data_sram_rdata, 32'h0);

    // Both requesters, addr_ok withheld 3 cycles: data locked
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 32'h00001000, 1, 32'h00002000, 0, 0, 32'h0);
      checkOutput($sformatf("t2_lock_addr_%0d", i), out_sram_addr, 32'h00002000);
      checkBit($sformatf("t2_lock_req_%0d", i), out_sram_req, 1'b1);
      checkBit($sformatf("t2_lock_aok_%0d", i), data_sram_addr_ok, 1'b0);
    end
    checkBit("t2_out_wr", out_sram_wr, 1'b1);
    checkOutput("t2_out_wdata", out_sram_wdata, 32'hCAFE0000);
    checkOutput("t2_out_wstrb", 32'(out_sram_wstrb), 32'h0000000f);
    applyStimulus(1, 32'h00001000, 1, 32'h00002000, 1, 0, 32'h0);
    checkBit("t2_data_addr_ok", data_sram_addr_ok, 1'b1);
    checkBit("t2_inst_addr_ok_n", inst_sram_addr_ok, 1'b0);
    applyStimulus(1, 32'h00001000, 0, 32'h0, 1, 0, 32'h0);
    checkOutput("t2_inst_addr", out_sram_addr, 32'h00001000);
    checkBit("t2_inst_addr_ok", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hAAAA0001);
    checkBit("t2_ret0_data", data_sram_data_ok, 1'b1);
    checkOutput("t2_ret0_rdata", data_sram_rdata, 32'hAAAA0001);
    checkBit("t2_ret0_inst_n", inst_sram_data_ok, 1'b0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'hBBBB0002);
    checkBit("t2_ret1_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t2_ret1_rdata", inst_sram_rdata, 32'hBBBB0002);

    // Starvation guard: 8 data wins, then inst, then data again
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1, 32'h00003000, 1, 32'h00004000 + 32'(k * 4), 1, (k > 0), 32'h0);
      checkBit($sformatf("t3_data_win_%0d", k), data_sram_addr_ok, 1'b1);
      checkBit($sformatf("t3_inst_wait_%0d", k), inst_sram_addr_ok, 1'b0);
    end
    applyStimulus(1, 32'h00003000, 1, 32'h00004020, 1, 1, 32'h0);
    checkBit("t3_inst_wins", inst_sram_addr_ok, 1'b1);
    checkBit("t3_data_loses", data_sram_addr_ok, 1'b0);
    checkOutput("t3_inst_addr", out_sram_addr, 32'h00003000);
    checkBit("t3_pop_data", data_sram_data_ok, 1'b1);
    applyStimulus(1, 32'h00003004, 1, 32'h00004020, 1, 1, 32'h12345678);
    checkBit("t3_cnt_cleared", data_sram_addr_ok, 1'b1);
    checkBit("t3_pop_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t3_pop_inst_rdata", inst_sram_rdata, 32'h12345678);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0);
    checkBit("t3_drain", data_sram_data_ok, 1'b1);

    // Fill the owner FIFO, then drain in order
    applyStimulus(1, 32'h00005000, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t4_push0", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 32'h0, 1, 32'h00006000, 1, 0, 32'h0);
    checkBit("t4_push1", data_sram_addr_ok, 1'b1);
    applyStimulus(1, 32'h00005004, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t4_push2", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 32'h0, 1, 32'h00006004, 1, 0, 32'h0);
    checkBit("t4_push3", data_sram_addr_ok, 1'b1);
    applyStimulus(1, 32'h00005008, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t4_full_req", out_sram_req, 1'b0);
    checkBit("t4_full_aok", inst_sram_addr_ok, 1'b0);
    applyStimulus(1, 32'h00005008, 0, 32'h0, 1, 1, 32'h11110000);
    checkBit("t4_pop_no_unblock", out_sram_req, 1'b0);
    checkBit("t4_ret0_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t4_ret0_rdata", inst_sram_rdata, 32'h11110000);
    applyStimulus(1, 32'h00005008, 0, 32'h0, 1, 1, 32'h22220000);
    checkBit("t4_reaccept", inst_sram_addr_ok, 1'b1);
    checkBit("t4_ret1_data", data_sram_data_ok, 1'b1);
    checkOutput("t4_ret1_rdata", data_sram_rdata, 32'h22220000);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h33330000);
    checkBit("t4_ret2_inst", inst_sram_data_ok, 1'b1);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h44440000);
    checkBit("t4_ret3_data", data_sram_data_ok, 1'b1);
    checkOutput("t4_ret3_rdata", data_sram_rdata, 32'h44440000);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h55550000);
    checkBit("t4_ret4_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t4_ret4_rdata", inst_sram_rdata, 32'h55550000);

    // Unexpected completion is sticky until reset
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h0BAD0BAD);
    checkBit("t5_no_inst_ok", inst_sram_data_ok, 1'b0);
    checkBit("t5_no_data_ok", data_sram_data_ok, 1'b0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("t5_err_set", err_unexpected_ok, 1'b1);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("t5_err_held", err_unexpected_ok, 1'b1);
    applyReset(1);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("t5_err_cleared", err_unexpected_ok, 1'b0);

    // Reset with two owners outstanding discards them
    applyStimulus(1, 32'h00007000, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t6_push0", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 32'h0, 1, 32'h00008000, 1, 0, 32'h0);
    checkBit("t6_push1", data_sram_addr_ok, 1'b1);
    applyReset(1);
    applyStimulus(1, 32'h00007100, 0, 32'h0, 1, 0, 32'h0);
    checkBit("t6_post_rst_accept", inst_sram_addr_ok, 1'b1);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h66660000);
    checkBit("t6_ret_inst", inst_sram_data_ok, 1'b1);
    checkOutput("t6_ret_rdata", inst_sram_rdata, 32'h66660000);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 1, 32'h77770000);
    checkBit("t6_no_stale_inst", inst_sram_data_ok, 1'b0);
    checkBit("t6_no_stale_data", data_sram_data_ok, 1'b0);
    applyStimulus(0, 32'h0, 0, 32'h0, 0, 0, 32'h0);
    checkBit("t6_empty_err", err_unexpected_ok, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
